muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32M extension: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Sits beside the single-cycle ALU in the execute stage and stalls the pipeline while it iterates.
- Uses one shift-add/shift-subtract step per cycle, selected by Funct3 when the main decoder flags an M-type op (Funct7 = 0000001).

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_sequencer.sv | 154 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types, funct3 encodings and decode helpers for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int XLEN_DFLT = 32;

    typedef logic [2:0] state_t;
    localparam state_t IDLE = 3'd0;
    localparam state_t PREP = 3'd1;
    localparam state_t CALC = 3'd2;
    localparam state_t FIX  = 3'd3;
    localparam state_t DONE = 3'd4;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f);
        return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f);
        return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide sequencer.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DFLT
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            stall;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result, stall
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result, stall
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: conditional add + right shift for multiply,
// restoring shift-subtract for divide (quotient bits enter at the bottom of acc).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DFLT
) (
    input  logic              div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   rem,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0]   rem_nxt
);
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          borrow;

    always_comb begin
        sum               = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted           = {rem, acc[XLEN-1]};
        {borrow, diff}    = {1'b0, shifted} - {2'b00, opnd};
        acc_nxt           = {sum, acc[XLEN-1:1]};
        rem_nxt           = rem;
        if (div) begin
            // shifted < 2*opnd always holds, so a non-borrowing difference fits XLEN bits
            acc_nxt = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ~borrow};
            rem_nxt = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer (IDLE->PREP->CALC->FIX->DONE), one step per cycle.
// Define MULDIV_FASTPATH_EN to finish divide-by-zero, signed overflow and zero-operand multiplies from PREP.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DFLT
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        f3;
    logic [XLEN-1:0]   a_raw;
    logic [XLEN-1:0]   b_raw;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   result_r;
    logic [2*XLEN-1:0] acc;
    logic              sa;
    logic              sb;
    logic              dz;
    logic              ovf;

    logic              div_op;
    logic              sgn_a;
    logic              sgn_b;
    logic              dz_c;
    logic              ovf_c;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN-1:0]   rem_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic              busy_w;
    logic              done_w;

    function automatic logic [XLEN-1:0] pick(input logic [2:0] f, input logic [2*XLEN-1:0] prod,
                                             input logic [XLEN-1:0] quo, input logic [XLEN-1:0] rmd,
                                             input logic dzf, input logic ovff, input logic [XLEN-1:0] a);
        logic [XLEN-1:0] v;
        v = rmd;
        case (f)
            F3_MUL:                       v = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: v = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              v = dzf ? '1 : (ovff ? {1'b1, {(XLEN-1){1'b0}}} : quo);
            F3_REM, F3_REMU:              v = dzf ? a : (ovff ? '0 : rmd);
        endcase
        return v;
    endfunction

    assign div_op = is_div(f3);
    assign sgn_a  = is_signed_a(f3) & a_raw[XLEN-1];
    assign sgn_b  = is_signed_b(f3) & b_raw[XLEN-1];
    assign mag_a  = sgn_a ? -a_raw : a_raw;
    assign mag_b  = sgn_b ? -b_raw : b_raw;
    assign dz_c   = (b_raw == '0);
    assign ovf_c  = is_signed_b(f3) && div_op && (a_raw == {1'b1, {(XLEN-1){1'b0}}}) && (b_raw == '1);

    // Sign correction of the magnitude result; remainder follows the dividend
    assign prod_fix = (sa ^ sb) ? -acc : acc;
    assign quo_fix  = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix  = sa ? -rem : rem;

`ifdef MULDIV_FASTPATH_EN
    logic fast_c;
    assign fast_c = div_op ? (dz_c | ovf_c) : ((a_raw == '0) || (b_raw == '0));
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div     (div_op),
        .acc     (acc),
        .rem     (rem),
        .opnd    (opnd),
        .acc_nxt (acc_nxt),
        .rem_nxt (rem_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            f3       <= '0;
            a_raw    <= '0;
            b_raw    <= '0;
            opnd     <= '0;
            rem      <= '0;
            acc      <= '0;
            result_r <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            dz       <= 1'b0;
            ovf      <= 1'b0;
        end else if ((state != IDLE) && bus.flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        f3    <= bus.funct3;
                        a_raw <= bus.op_a;
                        b_raw <= bus.op_b;
                        state <= PREP;
                    end
                end
                PREP: begin
                    sa    <= sgn_a;
                    sb    <= sgn_b;
                    dz    <= dz_c;
                    ovf   <= ovf_c;
                    cnt   <= CW'(XLEN - 1);
                    rem   <= '0;
                    if (div_op) begin
                        acc  <= {{XLEN{1'b0}}, mag_a};
                        opnd <= mag_b;
                    end else begin
                        acc  <= {{XLEN{1'b0}}, mag_b};
                        opnd <= mag_a;
                    end
                    state <= CALC;
`ifdef MULDIV_FASTPATH_EN
                    if (fast_c) begin
                        result_r <= pick(f3, '0, '0, '0, dz_c, ovf_c, a_raw);
                        state    <= DONE;
                    end
`endif
                end
                CALC: begin
                    acc <= acc_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    result_r <= pick(f3, prod_fix, quo_fix, rem_fix, dz, ovf, a_raw);
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_w     = (state != IDLE);
    assign done_w     = (state == DONE);
    assign bus.busy   = busy_w;
    assign bus.done   = done_w;
    assign bus.result = result_r;
    assign bus.stall  = (bus.start && (state == IDLE)) || (busy_w && !done_w);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized + directed bench for muldiv_sequencer against an ISA-level RV32M reference model.
module tb_muldiv_sequencer;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] last_res = '0;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RV32M semantics straight from the ISA definition, using 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FASTPATH_EN
        if (f3[2]) begin
            if (b == 0) return 2;
            if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        end else if (a == 0 || b == 0) begin
            return 2;
        end
`else
        if (f3 == 3'd7 && a == 32'hDEAD_BEEF && b == 32'hDEAD_BEEF) return XLEN + 3;
`endif
        return XLEN + 3;
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit hold);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        int          stall_n;
        exp     = ref_result(f3, a, b);
        exp_lat = ref_latency(f3, a, b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        #1;
        stall_n = bus.stall ? 1 : 0;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        #1;
        lat = 1;
        while (!bus.done && lat < 100) begin
            if (bus.stall) stall_n++;
            @(negedge clk);
            if (hold) begin
                bus.funct3 = 3'($urandom_range(0, 7));
                bus.op_a   = $urandom;
                bus.op_b   = $urandom;
            end
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("result", 64'(bus.result), 64'(exp));
        check("stall_in_done", 64'(bus.stall), 64'd0);
        check("busy_in_done", 64'(bus.busy), 64'd1);
        check("stall_cycles", 64'(stall_n), 64'(exp_lat));
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("done_single", 64'(bus.done), 64'd0);
        check("busy_after", 64'(bus.busy), 64'd0);
        check("result_hold", 64'(bus.result), 64'(exp));
        last_res = exp;
    endtask

    logic [2:0]  d_f3 [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd0};
    logic [31:0] d_a  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd13, 32'd13, 32'hFFFF_FFFB, 32'd0};
    logic [31:0] d_b  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'h1234_5678};

    initial begin
        int flush_dones;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        #3;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_op(d_f3[i], d_a[i], d_b[i], 1'b0);

        // flush in CALC: no done, result untouched, then a fresh op completes
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = 32'd100; bus.op_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        flush_dones = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (bus.done) flush_dones++;
        end
        check("busy_before_flush", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_done", 64'(bus.done | (flush_dones != 0)), 64'd0);
        check("flush_result", 64'(bus.result), 64'(last_res));
        run_op(3'd5, 32'd100, 32'd7, 1'b0);

        // flush together with start in IDLE is not an accept
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        check("flush_start_busy", 64'(bus.busy), 64'd0);

        // start held high while busy must not queue a second op
        run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd5; bus.op_b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_stall", 64'(bus.stall), 64'd0);
        check("midrst_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("postrst_busy", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 40; i++)
            run_op(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
